// File: rtl/gemm_sequencer.sv
// GEMM tile sequencer: weight load, activation stream and result drain
// for one tile on the SA_SIZE x SA_SIZE systolic array.
package GEMM_pkg;
  typedef enum logic [1:0] {
    CMD_NONE        = 2'd0,
    CMD_LOAD_WEIGHT = 2'd1,
    CMD_STREAM      = 2'd2
  } command_t;
endpackage

module gemm_sequencer
  import GEMM_pkg::*;
#(
  parameter int SA_SIZE  = 8,
  parameter int ROW_W    = 16,
  parameter int PIPE_LAT = 2 * SA_SIZE,
  localparam int WA      = (SA_SIZE > 1) ? $clog2(SA_SIZE) : 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [ROW_W-1:0] num_rows,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output command_t         cmd,
  output logic             w_rd_en,
  output logic [WA-1:0]    w_rd_addr,
  output logic             act_rd_en,
  output logic [ROW_W-1:0] act_rd_addr,
  output logic             res_wr_en,
  output logic [ROW_W-1:0] res_wr_addr,
  input  logic             res_ready
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [ROW_W:0] PL     = (ROW_W+1)'(PIPE_LAT);
  localparam logic [ROW_W:0] ONE    = (ROW_W+1)'(1);
  localparam logic [WA-1:0]  W_LAST = WA'(SA_SIZE - 1);

  logic [1:0]       state_q;
  logic             busy_q;
  logic             done_q;
  logic             w_en_q;
  logic [WA-1:0]    w_addr_q;
  logic             act_en_q;
  logic [ROW_W-1:0] act_addr_q;
  logic             res_en_q;
  logic [ROW_W-1:0] res_addr_q;
  logic [ROW_W-1:0] m_q;
  logic [ROW_W:0]   s_q;
  logic [ROW_W:0]   s_nx;
  logic [ROW_W:0]   s_last;

  // step counter is one bit wider than M so M+PIPE_LAT cannot wrap
  assign s_nx   = s_q + ONE;
  assign s_last = {1'b0, m_q} + PL - ONE;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      w_en_q     <= 1'b0;
      w_addr_q   <= '0;
      act_en_q   <= 1'b0;
      act_addr_q <= '0;
      res_en_q   <= 1'b0;
      res_addr_q <= '0;
      m_q        <= '0;
      s_q        <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort && busy_q) begin
        state_q    <= ST_IDLE;
        busy_q     <= 1'b0;
        w_en_q     <= 1'b0;
        w_addr_q   <= '0;
        act_en_q   <= 1'b0;
        act_addr_q <= '0;
        res_en_q   <= 1'b0;
        res_addr_q <= '0;
        s_q        <= '0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (!busy_q) begin
              if (start) begin
                busy_q <= 1'b1;
                m_q    <= num_rows;
              end
            end else if (m_q == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q  <= ST_LOAD;
              w_en_q   <= 1'b1;
              w_addr_q <= '0;
            end
          end
          ST_LOAD: begin
            if (w_addr_q == W_LAST) begin
              state_q    <= ST_STREAM;
              w_en_q     <= 1'b0;
              w_addr_q   <= '0;
              s_q        <= '0;
              act_en_q   <= 1'b1;
              act_addr_q <= '0;
              res_en_q   <= (PL == '0);
              res_addr_q <= '0;
            end else begin
              w_addr_q <= w_addr_q + 1'b1;
            end
          end
          ST_STREAM: begin
            // a stall holds every register, freezing the datapath
            if (res_ready) begin
              if (s_q == s_last) begin
                state_q    <= ST_DONE;
                done_q     <= 1'b1;
                act_en_q   <= 1'b0;
                act_addr_q <= '0;
                res_en_q   <= 1'b0;
                res_addr_q <= '0;
                s_q        <= '0;
              end else begin
                s_q      <= s_nx;
                act_en_q <= (s_nx < {1'b0, m_q});
                res_en_q <= (s_nx >= PL);
                if (s_nx < {1'b0, m_q})
                  act_addr_q <= act_addr_q + 1'b1;
                if (res_en_q)
                  res_addr_q <= res_addr_q + 1'b1;
              end
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    cmd = CMD_NONE;
    unique case (1'b1)
      (state_q == ST_LOAD):                 cmd = CMD_LOAD_WEIGHT;
      (state_q == ST_STREAM && res_ready):  cmd = CMD_STREAM;
      default:                              cmd = CMD_NONE;
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign w_rd_en     = w_en_q;
  assign w_rd_addr   = w_addr_q;
  assign act_rd_en   = act_en_q & res_ready;
  assign act_rd_addr = act_addr_q;
  assign res_wr_en   = res_en_q & res_ready;
  assign res_wr_addr = res_addr_q;

endmodule

// File: tb/tb_gemm_sequencer.sv
// Scoreboard bench for gemm_sequencer: per-cycle expected outputs come
// from a job-plan model built with plain loops over the row count.
module tb_gemm_sequencer;
  import GEMM_pkg::*;

  localparam int SA = 4;
  localparam int PL = 8;
  localparam int RW = 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [RW-1:0] num_rows = '0;
  logic          abort = 1'b0;
  logic          res_ready = 1'b0;
  logic          busy, done, w_rd_en, act_rd_en, res_wr_en;
  command_t      cmd;
  logic [1:0]    w_rd_addr;
  logic [RW-1:0] act_rd_addr, res_wr_addr;

  gemm_sequencer #(.SA_SIZE(SA), .ROW_W(RW), .PIPE_LAT(PL)) dut (
    .clk(clk), .resetn(resetn), .start(start), .num_rows(num_rows),
    .abort(abort), .busy(busy), .done(done), .cmd(cmd),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
    .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr),
    .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr),
    .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic [1:0]    cmd;
    logic          w_en;
    logic [1:0]    w_addr;
    logic          a_en;
    logic [RW-1:0] a_addr;
    logic          r_en;
    logic [RW-1:0] r_addr;
  } rec_t;

  rec_t exp_q[$];
  rec_t plan[$];
  bit   stl[$];
  int   passed = 0;
  int   total = 0;
  int   cyc = 0;

  function automatic rec_t zrec();
    rec_t r;
    r = '0;
    return r;
  endfunction

  // Job as seen at the pins: accept, SA weight rows, M+PL stream steps, done.
  task automatic build(input int m);
    rec_t r;
    r = zrec(); r.busy = 1'b1;
    plan.push_back(r); stl.push_back(1'b0);
    if (m > 0) begin
      for (int i = 0; i < SA; i++) begin
        r = zrec(); r.busy = 1'b1; r.cmd = CMD_LOAD_WEIGHT;
        r.w_en = 1'b1; r.w_addr = 2'(i);
        plan.push_back(r); stl.push_back(1'b0);
      end
      for (int s = 0; s < m + PL; s++) begin
        r = zrec(); r.busy = 1'b1; r.cmd = CMD_STREAM;
        r.a_en = (s < m); r.a_addr = RW'(s);
        r.r_en = (s >= PL); r.r_addr = RW'(s - PL);
        plan.push_back(r); stl.push_back(1'b1);
      end
    end
    r = zrec(); r.busy = 1'b1; r.done = 1'b1;
    plan.push_back(r); stl.push_back(1'b0);
  endtask

  task automatic step(input logic st, input int nr, input logic ab,
                      input logic rr);
    rec_t e;
    bit   stall;
    @(posedge clk); #1;
    start = st; num_rows = RW'(nr); abort = ab; res_ready = rr;
    stall = (plan.size() != 0) && stl[0] && !rr;
    if (plan.size() == 0) e = zrec();
    else if (stall) begin e = zrec(); e.busy = 1'b1; end
    else e = plan[0];
    exp_q.push_back(e);
    if (plan.size() != 0) begin
      if (ab) begin plan.delete(); stl.delete(); end
      else if (!stall) begin void'(plan.pop_front()); void'(stl.pop_front()); end
    end else if (st) build(nr);
  endtask

  task automatic idle_until_free(input int extra);
    for (int i = 0; i < 200 && plan.size() != 0; i++) step(0, 0, 0, 1);
    for (int i = 0; i < extra; i++) step(0, 0, 0, 1);
  endtask

  task automatic check_zero(input string nm);
    total++;
    if (busy === 1'b0 && done === 1'b0 && cmd === CMD_NONE &&
        w_rd_en === 1'b0 && act_rd_en === 1'b0 && res_wr_en === 1'b0 &&
        w_rd_addr === '0 && act_rd_addr === '0 && res_wr_addr === '0)
      passed++;
    else
      $display("FAIL %s: busy=%b done=%b cmd=%0d w=%b a=%b r=%b, need all 0",
               nm, busy, done, cmd, w_rd_en, act_rd_en, res_wr_en);
  endtask

  always @(negedge clk) begin
    rec_t e;
    bit ok;
    if (resetn && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      cyc++;
      ok = (busy === e.busy) && (done === e.done) && (cmd === e.cmd) &&
           (w_rd_en === e.w_en) && (act_rd_en === e.a_en) &&
           (res_wr_en === e.r_en) &&
           (!e.w_en || w_rd_addr === e.w_addr) &&
           (!e.a_en || act_rd_addr === e.a_addr) &&
           (!e.r_en || res_wr_addr === e.r_addr);
      total++;
      if (ok) passed++;
      else
        $display("FAIL cycle%0d: got b%b d%b c%0d w%b/%0d a%b/%0d r%b/%0d need b%b d%b c%0d w%b/%0d a%b/%0d r%b/%0d",
                 cyc, busy, done, cmd, w_rd_en, w_rd_addr, act_rd_en,
                 act_rd_addr, res_wr_en, res_wr_addr, e.busy, e.done, e.cmd,
                 e.w_en, e.w_addr, e.a_en, e.a_addr, e.r_en, e.r_addr);
    end
  end

  initial begin
    #2 check_zero("reset_initial");
    #20 resetn = 1'b1;

    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    // basic M=3 job
    step(1, 3, 0, 1);
    idle_until_free(2);
    // two stall cycles at step 5
    for (int i = 0; i < 25; i++)
      step(i == 0, 3, 0, !(i == 11 || i == 12));
    idle_until_free(1);
    // M=0
    step(1, 0, 0, 1);
    idle_until_free(2);
    // start during STREAM and in the done cycle, then a fresh job
    for (int i = 0; i < 19; i++)
      step(i == 0 || i == 10 || i == 17, (i == 18) ? 2 : 3, 0, 1);
    idle_until_free(1);
    // abort at step 6, then M=2
    for (int i = 0; i < 13; i++) step(i == 0, 3, i == 12, 1);
    step(0, 0, 0, 1);
    step(1, 2, 0, 1);
    idle_until_free(1);

    // randomized jobs with backpressure, stray starts and rare aborts
    for (int j = 0; j < 30; j++) begin
      step(1, int'($urandom_range(0, 12)), 0, $urandom_range(0, 3) != 0);
      for (int i = 0; i < 300 && plan.size() != 0; i++) begin
        logic ab;
        ab = ($urandom_range(0, 99) < 2);
        step(!ab && $urandom_range(0, 9) == 0, int'($urandom_range(0, 12)),
             ab, $urandom_range(0, 3) != 0);
      end
      step(0, 0, 0, $urandom_range(0, 1) == 1);
    end

    // asynchronous reset between edges during LOAD_W
    step(1, 5, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    #2 resetn = 1'b0;
    #1 check_zero("reset_mid_load");
    exp_q.delete(); plan.delete(); stl.delete();
    @(posedge clk); #1 check_zero("reset_held");
    @(negedge clk); #2 resetn = 1'b1;
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
    step(1, 4, 0, 1);
    idle_until_free(2);

    @(negedge clk); #1;
    total++;
    if (exp_q.size() == 0 && plan.size() == 0) passed++;
    else $display("FAIL drain: %0d records left, need 0", exp_q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
